cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller that sequences the single-port cache data RAM on behalf of one CPU requester and one main-memory port. It holds the tag/valid store, compares tags, drives the data RAM's address, data and write-enable, and runs the memory handshake on misses and on every write. It sits between the CPU interface and the cache data RAM / memory bus inside the cache top level.

## Interface
- ADDR_W, 16: CPU/memory byte-address width.
- INDEX_W, 6: index width; cache depth is 2**INDEX_W (64) lines.
- DATA_W, 8: data width, matching the data RAM word.
- Clk  in  1  single clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- CpuReq  in  1  request valid; held with its payload until CpuReady.
- CpuWe  in  1  1 = write, 0 = read.
- CpuAddr  in  ADDR_W  request address; index = [INDEX_W-1:0], tag = [ADDR_W-1:INDEX_W].
- CpuWdata  in  DATA_W  write data.
- Flush  in  1  one-cycle pulse; invalidates all lines.
- CpuReady  out  1  one-cycle completion pulse.
- CpuRdata  out  DATA_W  read data, valid while CpuReady is high.
- RamAddr  out  INDEX_W  data RAM address.
- RamDin  out  DATA_W  data RAM write data.
- RamWrite  out  1  data RAM write enable.
- RamDout  in  DATA_W  data RAM registered read data.
- MemReq  out  1  memory request, held until MemAck.
- MemWe  out  1  memory write select.
- MemAddr  out  ADDR_W  memory address (latched CpuAddr).
- MemWdata  out  DATA_W  memory write data.
- MemRdata  in  DATA_W  memory read data, valid with MemAck.
- MemAck  in  1  memory completion, one cycle.

## Operation
- The data RAM captures RamDout on the rising edge from RamAddr and writes on the falling edge when RamWrite is high. The controller keeps RamAddr, RamDin and RamWrite stable for the whole cycle.
- States: IDLE, COMPARE, MEM_RD, MEM_WR, RESP.
- IDLE:
  - RamAddr = CpuAddr index, combinational, so the accepting edge also reads the line.
  - Flush high: clear all valid bits and stay in IDLE. Flush has priority over a simultaneous CpuReq, which is accepted on the next cycle.
  - Otherwise, with CpuReq high: latch address, data and we, then go to COMPARE.
- COMPARE: hit = valid[index] && tag match.
  - Read hit: register CpuRdata = RamDout and go to RESP.
  - Read miss: go to MEM_RD.
  - Write hit: RamWrite = 1 and RamDin = latched data this cycle, then go to MEM_WR.
  - Write miss: go to MEM_WR with no RAM write and no allocate.
- MEM_RD: MemReq = 1, MemWe = 0. In the cycle MemAck is high:
  - RamWrite = 1 and RamDin = MemRdata.
  - Set valid and tag for the index.
  - CpuRdata <= MemRdata, then go to RESP.
- MEM_WR: MemReq = 1, MemWe = 1, MemWdata = latched data. On MemAck, go to RESP.
- RESP: CpuReady = 1 for one cycle, then go to IDLE. CpuReq is not sampled in RESP.
- Outside IDLE, RamAddr = latched index.
- Flush outside IDLE is ignored; the requester retries it.
- MemAck is ignored unless the state is MEM_RD or MEM_WR.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE and all valid bits clear.
  - CpuReady, MemReq, MemWe and RamWrite = 0.
  - CpuRdata, MemAddr and MemWdata = 0.
  - An outstanding memory transaction is abandoned, and the memory side must tolerate a dropped MemReq.
- Read hit: CpuReady is high in the 2nd cycle after the accepting edge (IDLE → COMPARE → RESP).
- Miss or any write: CpuReady is high in the cycle after the edge that samples MemAck.
  - MemReq rises on the edge entering MEM_*.
  - MemReq falls on the edge that samples MemAck.
  - With a zero-wait memory, MemAck arrives in the first MEM_* cycle; total latency is then 3 edges.
- MemAddr, MemWe and MemWdata are stable throughout MemReq.
- Back-to-back: minimum of one IDLE cycle between requests.

## Structure
- Shared header/package cache_defs:
  - ADDR, INDEX, TAG and DATA range macros.
  - CACHESIZE.
  - State encodings.
- Sub-module tag_store: 2**INDEX_W × (ADDR_W−INDEX_W) tag array plus a valid-bit vector.
  - The valid-bit vector has asynchronous clear and synchronous flush.
  - It provides a combinational hit output.
- The controller FSM is the parent. The data RAM is a sibling instance in the cache top level.

## Test plan
- Reset, then read 0x1234 with memory returning 0xA5 after 3 cycles:
  - MEM_RD is entered with MemAddr = 0x1234.
  - RAM[0x34] is written with 0xA5.
  - CpuReady is pulsed with CpuRdata = 0xA5.
  - tag[0x34] = 0x048.
- Read 0x1234 again: hit, no MemReq, CpuReady at edge +2, CpuRdata = 0xA5.
- Write 0x5A to 0x1234 (hit):
  - RamWrite is high in COMPARE and MemReq carries MemWe = 1, MemWdata = 0x5A.
  - A following read returns 0x5A without MemReq.
- Write 0x77 to 0x2234 (miss, index 0x34, tag 0x088): memory write only, no RamWrite. A read of 0x1234 still hits with 0x5A.
- Flush and CpuReq asserted together in IDLE:
  - The flush takes effect and the request is accepted one cycle later.
  - The request then misses.
- Reset_n pulsed low in MEM_RD before MemAck: MemReq drops immediately, no valid bit is set, and a late MemAck is ignored.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared constants for the direct-mapped write-through cache controller:
// default geometry and FSM state encodings.
package cache_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_INDEX_W = 6;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_TAG_W   = DEF_ADDR_W - DEF_INDEX_W;
    localparam int unsigned CACHESIZE   = 1 << DEF_INDEX_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COMPARE = 3'd1;
    localparam logic [2:0] S_MEM_RD  = 3'd2;
    localparam logic [2:0] S_MEM_WR  = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

endpackage

// File: rtl/cache_ctrl_tag_store.sv
// Tag array plus valid-bit vector for the direct-mapped cache; lookup and
// update share one index, and the hit output is purely combinational.
module cache_ctrl_tag_store #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned TAG_W   = 10
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Flush,
    input  logic [INDEX_W-1:0] Index,
    input  logic [TAG_W-1:0]   Tag,
    input  logic               Write,
    output logic               Hit
);

    localparam int unsigned Lines = 1 << INDEX_W;

    logic [TAG_W-1:0] tagMem [Lines];
    logic [Lines-1:0] validQ;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            validQ <= '0;
        end else if (Flush) begin
            validQ <= '0;
        end else if (Write) begin
            validQ[Index] <= 1'b1;
        end
    end

    // Tags need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge Clk) begin
        if (Write) begin
            tagMem[Index] <= Tag;
        end
    end

    assign Hit = validQ[Index] && (tagMem[Index] == Tag);

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller: owns the
// tag/valid store, sequences the data RAM and runs the memory handshake.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INDEX_W = DEF_INDEX_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               CpuReq,
    input  logic               CpuWe,
    input  logic [ADDR_W-1:0]  CpuAddr,
    input  logic [DATA_W-1:0]  CpuWdata,
    input  logic               Flush,
    output logic               CpuReady,
    output logic [DATA_W-1:0]  CpuRdata,
    output logic [INDEX_W-1:0] RamAddr,
    output logic [DATA_W-1:0]  RamDin,
    output logic               RamWrite,
    input  logic [DATA_W-1:0]  RamDout,
    output logic               MemReq,
    output logic               MemWe,
    output logic [ADDR_W-1:0]  MemAddr,
    output logic [DATA_W-1:0]  MemWdata,
    input  logic [DATA_W-1:0]  MemRdata,
    input  logic               MemAck
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W;

    logic [2:0]         stateQ, stateD;
    logic [ADDR_W-1:0]  addrQ;
    logic [DATA_W-1:0]  wdataQ;
    logic               weQ;
    logic [DATA_W-1:0]  rdataQ;
    logic               hit;
    logic               tagWrite;
    logic               flushAll;
    logic               accept;
    logic [INDEX_W-1:0] idxQ;
    logic [TAG_W-1:0]   tagQ;

    assign idxQ = addrQ[INDEX_W-1:0];
    assign tagQ = addrQ[ADDR_W-1:INDEX_W];

    cache_ctrl_tag_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_store (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Flush   (flushAll),
        .Index   (idxQ),
        .Tag     (tagQ),
        .Write   (tagWrite),
        .Hit     (hit)
    );

    // Flush wins over a simultaneous request; the request is taken next cycle.
    assign flushAll = (stateQ == S_IDLE) && Flush;
    assign accept   = (stateQ == S_IDLE) && !Flush && CpuReq;

    always_comb begin
        stateD   = stateQ;
        RamWrite = 1'b0;
        RamDin   = wdataQ;
        tagWrite = 1'b0;
        case (stateQ)
            S_IDLE: begin
                if (accept) begin
                    stateD = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (weQ) begin
                    RamWrite = hit;
                    stateD   = S_MEM_WR;
                end else begin
                    stateD = hit ? S_RESP : S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (MemAck) begin
                    RamWrite = 1'b1;
                    RamDin   = MemRdata;
                    tagWrite = 1'b1;
                    stateD   = S_RESP;
                end
            end
            S_MEM_WR: begin
                if (MemAck) begin
                    stateD = S_RESP;
                end
            end
            S_RESP:  stateD = S_IDLE;
            default: stateD = S_IDLE;
        endcase
    end

    // In IDLE the RAM address follows the CPU so the accepting edge reads the line.
    assign RamAddr = (stateQ == S_IDLE) ? CpuAddr[INDEX_W-1:0] : idxQ;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stateQ <= S_IDLE;
            addrQ  <= '0;
            wdataQ <= '0;
            weQ    <= 1'b0;
            rdataQ <= '0;
        end else begin
            stateQ <= stateD;
            if (accept) begin
                addrQ  <= CpuAddr;
                wdataQ <= CpuWdata;
                weQ    <= CpuWe;
            end
            if (stateQ == S_COMPARE && !weQ && hit) begin
                rdataQ <= RamDout;
            end else if (stateQ == S_MEM_RD && MemAck) begin
                rdataQ <= MemRdata;
            end
        end
    end

    assign CpuReady = (stateQ == S_RESP);
    assign CpuRdata = rdataQ;
    assign MemReq   = (stateQ == S_MEM_RD) || (stateQ == S_MEM_WR);
    assign MemWe    = (stateQ == S_MEM_WR);
    assign MemAddr  = addrQ;
    assign MemWdata = wdataQ;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: data RAM and main memory are modelled
// here, and a line-level cache model predicts every cycle of each transaction.
module tb_cache_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        CpuReq;
    logic        CpuWe;
    logic [15:0] CpuAddr;
    logic [7:0]  CpuWdata;
    logic        Flush;
    logic        CpuReady;
    logic [7:0]  CpuRdata;
    logic [5:0]  RamAddr;
    logic [7:0]  RamDin;
    logic        RamWrite;
    logic [7:0]  RamDout;
    logic        MemReq;
    logic        MemWe;
    logic [15:0] MemAddr;
    logic [7:0]  MemWdata;
    logic [7:0]  MemRdata;
    logic        MemAck;

    int nTests = 0;
    int nFail  = 0;

    cache_ctrl dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .CpuReq   (CpuReq),
        .CpuWe    (CpuWe),
        .CpuAddr  (CpuAddr),
        .CpuWdata (CpuWdata),
        .Flush    (Flush),
        .CpuReady (CpuReady),
        .CpuRdata (CpuRdata),
        .RamAddr  (RamAddr),
        .RamDin   (RamDin),
        .RamWrite (RamWrite),
        .RamDout  (RamDout),
        .MemReq   (MemReq),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWdata (MemWdata),
        .MemRdata (MemRdata),
        .MemAck   (MemAck)
    );

    always #5 Clk = ~Clk;

    // Sibling data RAM: registered read on the rising edge, write on the falling edge.
    logic [7:0] ram [64];
    always @(posedge Clk) RamDout <= ram[RamAddr];
    always @(negedge Clk) if (RamWrite) ram[RamAddr] <= RamDin;

    // Reference model: main memory plus per-line valid/tag/data.
    logic [7:0] mem [65536];
    logic       mValid [64];
    logic [9:0] mTag [64];
    logic [7:0] mData [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
    endtask

    // Starts at posedge+1 with the DUT in IDLE; ends at posedge+1 back in IDLE.
    task automatic doTxn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         input int delay, input logic withFlush,
                         output logic [7:0] obsRd, output int obsReadyC,
                         output int obsMem, output int obsRamWr);
        logic [5:0] idx;
        logic [9:0] tag;
        logic       hit;
        logic [7:0] expRd;
        int         respC;
        int         memCnt;
        logic       expMemReq;
        logic       expRamWr;
        idx = addr[5:0];
        tag = addr[15:6];
        obsRd = 8'h00; obsReadyC = 0; obsMem = 0; obsRamWr = 0; memCnt = 0;
        CpuReq = 1'b1; CpuWe = we; CpuAddr = addr; CpuWdata = wd; Flush = withFlush;
        if (withFlush) begin
            modelReset();
            @(posedge Clk); #1;
            Flush = 1'b0;
            @(negedge Clk);
            chk("flushHoldsIdle.ready", {31'd0, CpuReady}, 32'd0);
            chk("flushHoldsIdle.memReq", {31'd0, MemReq}, 32'd0);
        end
        hit   = mValid[idx] && (mTag[idx] == tag);
        expRd = hit ? mData[idx] : mem[addr];
        respC = (!we && hit) ? 2 : 3 + delay;
        for (int c = 1; c <= respC; c++) begin
            @(posedge Clk); #1;
            MemAck = 1'b0;
            if (MemReq) begin
                memCnt++;
                if (memCnt == delay + 1) begin
                    MemAck   = 1'b1;
                    MemRdata = we ? 8'($urandom) : mem[addr];
                end
            end
            @(negedge Clk);
            expMemReq = !(!we && hit) && c >= 2 && c < respC;
            expRamWr  = (c == 1 && we && hit) || (!we && !hit && c == respC - 1);
            if (CpuReady && obsReadyC == 0) begin
                obsReadyC = c;
                obsRd = CpuRdata;
            end
            if (MemReq) obsMem++;
            if (RamWrite) obsRamWr++;
            chk("cpuReady", {31'd0, CpuReady}, {31'd0, c == respC});
            chk("memReq", {31'd0, MemReq}, {31'd0, expMemReq});
            chk("ramWrite", {31'd0, RamWrite}, {31'd0, expRamWr});
            if (expMemReq) begin
                chk("memWe", {31'd0, MemWe}, {31'd0, we});
                chk("memAddr", {16'd0, MemAddr}, {16'd0, addr});
                if (we) chk("memWdata", {24'd0, MemWdata}, {24'd0, wd});
            end
            if (expRamWr) begin
                chk("ramAddr", {26'd0, RamAddr}, {26'd0, idx});
                chk("ramDin", {24'd0, RamDin}, {24'd0, (we ? wd : mem[addr])});
            end
            if (c == respC && !we) chk("cpuRdata", {24'd0, CpuRdata}, {24'd0, expRd});
        end
        CpuReq = 1'b0;
        MemAck = 1'b0;
        if (we) begin
            mem[addr] = wd;
            if (hit) mData[idx] = wd;
        end else if (!hit) begin
            mValid[idx] = 1'b1;
            mTag[idx]   = tag;
            mData[idx]  = mem[addr];
        end
        @(posedge Clk); #1;
    endtask

    logic [7:0] rd;
    int         rc, mc, rw;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
        mem[16'h1234] = 8'hA5;
        for (int i = 0; i < 64; i++) ram[i] = 8'h00;
        modelReset();
        Reset_n = 1'b0; CpuReq = 1'b0; CpuWe = 1'b0; CpuAddr = 16'h0; CpuWdata = 8'h0;
        Flush = 1'b0; MemRdata = 8'h0; MemAck = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst.cpuReady", {31'd0, CpuReady}, 32'd0);
        chk("rst.memReq", {31'd0, MemReq}, 32'd0);
        chk("rst.memWe", {31'd0, MemWe}, 32'd0);
        chk("rst.ramWrite", {31'd0, RamWrite}, 32'd0);
        chk("rst.cpuRdata", {24'd0, CpuRdata}, 32'd0);
        chk("rst.memAddr", {16'd0, MemAddr}, 32'd0);
        chk("rst.memWdata", {24'd0, MemWdata}, 32'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // Directed scenarios with hand-computed latencies and data.
        doTxn(1'b0, 16'h1234, 8'h00, 3, 1'b0, rd, rc, mc, rw);
        chk("miss.rdata", {24'd0, rd}, 32'hA5);
        chk("miss.latency", rc, 6);
        chk("miss.memCycles", mc, 4);
        chk("miss.ramLine", {24'd0, ram[6'h34]}, 32'hA5);
        doTxn(1'b0, 16'h1234, 8'h00, 0, 1'b0, rd, rc, mc, rw);
        chk("hit.rdata", {24'd0, rd}, 32'hA5);
        chk("hit.latency", rc, 2);
        chk("hit.memCycles", mc, 0);
        doTxn(1'b1, 16'h1234, 8'h5A, 0, 1'b0, rd, rc, mc, rw);
        chk("wrHit.ramWrites", rw, 1);
        chk("wrHit.latency", rc, 3);
        chk("wrHit.ramLine", {24'd0, ram[6'h34]}, 32'h5A);
        doTxn(1'b0, 16'h1234, 8'h00, 0, 1'b0, rd, rc, mc, rw);
        chk("rdAfterWr.rdata", {24'd0, rd}, 32'h5A);
        chk("rdAfterWr.memCycles", mc, 0);
        doTxn(1'b1, 16'h2234, 8'h77, 1, 1'b0, rd, rc, mc, rw);
        chk("wrMiss.ramWrites", rw, 0);
        chk("wrMiss.memCycles", mc, 2);
        doTxn(1'b0, 16'h1234, 8'h00, 0, 1'b0, rd, rc, mc, rw);
        chk("noAlloc.rdata", {24'd0, rd}, 32'h5A);
        chk("noAlloc.memCycles", mc, 0);
        doTxn(1'b0, 16'h1234, 8'h00, 0, 1'b1, rd, rc, mc, rw);
        chk("flushMiss.memCycles", mc, 1);
        chk("flushMiss.rdata", {24'd0, rd}, 32'h5A);

        // Reset in MEM_RD before MemAck, then a late MemAck.
        CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 16'h0ABC;
        @(posedge Clk); @(posedge Clk); #1;
        chk("rstMid.memReqUp", {31'd0, MemReq}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("rstMid.memReqDrop", {31'd0, MemReq}, 32'd0);
        chk("rstMid.memAddr", {16'd0, MemAddr}, 32'd0);
        chk("rstMid.cpuReady", {31'd0, CpuReady}, 32'd0);
        CpuReq = 1'b0;
        modelReset();
        @(posedge Clk); #1;
        Reset_n = 1'b1; MemAck = 1'b1; MemRdata = 8'hEE;
        @(negedge Clk);
        chk("lateAck.ramWrite", {31'd0, RamWrite}, 32'd0);
        @(posedge Clk); #1;
        MemAck = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            chk("lateAck.idleReady", {31'd0, CpuReady}, 32'd0);
            chk("lateAck.idleMemReq", {31'd0, MemReq}, 32'd0);
        end
        @(posedge Clk); #1;
        doTxn(1'b0, 16'h0ABC, 8'h00, 0, 1'b0, rd, rc, mc, rw);
        chk("afterRst.missAbandoned", mc, 1);
        doTxn(1'b0, 16'h1234, 8'h00, 0, 1'b0, rd, rc, mc, rw);
        chk("afterRst.missOldLine", mc, 1);

        // Randomised traffic over a few tags and indices to force conflicts.
        for (int n = 0; n < 250; n++) begin
            logic [15:0] a;
            a = {8'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
            a = {a[7:6], 8'd0, a[5:0]};
            doTxn(1'($urandom_range(0, 2) == 0), a, 8'($urandom), $urandom_range(0, 3),
                  1'($urandom_range(0, 15) == 0), rd, rc, mc, rw);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
